// File: rtl/io_bus_master_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : io_bus_master_if
// Description : Core request/response handshakes plus the 4-bit-addressed
//               I/O peripheral bus, bundled for io_bus_master.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_bus_master_if #(
    parameter int BITS = 16
);
    // core request channel
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [3:0]      req_addr;
    logic [BITS-1:0] req_wdata;

    // core response channel
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_write;
    logic [BITS-1:0] rsp_rdata;

    // peripheral bus
    logic            io_en;
    logic            io_r_or_w;
    logic [3:0]      io_addr;
    logic [BITS-1:0] io_wdata;
    logic [BITS-1:0] io_rdata;

    // bus initiator view
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, io_rdata,
        output req_ready, rsp_valid, rsp_write, rsp_rdata,
               io_en, io_r_or_w, io_addr, io_wdata
    );

    // core + peripheral view
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, io_rdata,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata,
               io_en, io_r_or_w, io_addr, io_wdata
    );
endinterface
`default_nettype wire

// File: rtl/io_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : io_bus_master
// Description : CPU-side initiator for the I/O peripheral bus. Buffers core
//               requests in a 2-entry FIFO, runs each as one timed bus access
//               and returns read data / write completion to the core.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_master #(
    parameter int BITS        = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    io_bus_master_if.master bus,
    output logic            busy
);

    // FIFO entry layout: {write, addr[3:0], wdata[BITS-1:0]}
    localparam int          c_ENTRY_W = BITS + 5;
    localparam logic [3:0]  c_WAIT    = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_ENTRY_W-1:0]   r_fifo_mem [2];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;

    logic [3:0]             r_wait;
    logic                   r_io_en;
    logic                   r_io_r_or_w;
    logic [3:0]             r_io_addr;
    logic [BITS-1:0]        r_io_wdata;
    logic                   r_rsp_valid;
    logic                   r_rsp_write;
    logic [BITS-1:0]        r_rsp_rdata;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_req_ready;
    logic                   w_push;
    logic                   w_issue;
    logic                   w_complete;
    logic                   w_wait_dec;
    logic                   w_rsp_clear;
    logic [c_ENTRY_W-1:0]   w_head;

    assign w_full      = (r_count == 2'd2);
    assign w_empty     = (r_count == 2'd0);
    // Held low while in reset so nothing is accepted before the FIFO is usable.
    assign w_req_ready = rst_n & ~w_full;
    assign w_push      = bus.req_valid & w_req_ready;
    assign w_head      = r_fifo_mem[r_rd_ptr];

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_write = r_rsp_write;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.io_en     = r_io_en;
    assign bus.io_r_or_w = r_io_r_or_w;
    assign bus.io_addr   = r_io_addr;
    assign bus.io_wdata  = r_io_wdata;
    assign busy          = ~w_empty | (r_state != S_IDLE);

    // FIFO storage: payload only, validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {bus.req_write, bus.req_addr, bus.req_wdata};
        end
    end

    // FIFO pointers and occupancy; a pop is the FSM issuing the head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_issue) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_complete  = 1'b0;
        w_wait_dec  = 1'b0;
        w_rsp_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_wait != 4'd0) begin
                    w_wait_dec = 1'b1;
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_clear = 1'b1;
                    // Chaining straight to ACCESS still leaves this RESP cycle
                    // with io_en low between the two accesses.
                    if (!w_empty) begin
                        w_issue     = 1'b1;
                        w_state_nxt = S_ACCESS;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus drive, wait counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait      <= 4'd0;
            r_io_en     <= 1'b0;
            r_io_r_or_w <= 1'b0;
            r_io_addr   <= 4'd0;
            r_io_wdata  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_issue) begin
                r_io_en     <= 1'b1;
                r_io_r_or_w <= w_head[c_ENTRY_W-1];
                r_io_addr   <= w_head[BITS+3:BITS];
                r_io_wdata  <= w_head[BITS-1:0];
                r_wait      <= c_WAIT;
            end else if (w_wait_dec) begin
                r_wait <= r_wait - 4'd1;
            end
            if (w_complete) begin
                // Address and write data stay put; only the enable drops.
                r_io_en     <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_write <= r_io_r_or_w;
                r_rsp_rdata <= r_io_r_or_w ? '0 : bus.io_rdata;
            end
            if (w_rsp_clear) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
